// File: rtl/ym_prescaler_prog_if.sv
// Phase-enable bus for ym_prescaler_prog: chip-clock level and divider in, phase enables out.
// The master drives PHI/div; the slave (the prescaler) drives the enables and reset_fsm.
interface ym_prescaler_prog_if #(
    parameter int unsigned DIV_W = 4
);
    logic             PHI;
    logic [DIV_W-1:0] div;
    logic             c1;
    logic             c2;
    logic             cyc;
    logic             reset_fsm;

    modport master (
        output PHI,
        output div,
        input  c1,
        input  c2,
        input  cyc,
        input  reset_fsm
    );

    modport slave (
        input  PHI,
        input  div,
        output c1,
        output c2,
        output cyc,
        output reset_fsm
    );
endinterface

// File: rtl/ym_prescaler_prog.sv
// Programmable two-phase clock-enable generator (even divide-by-2h of the PHI tick rate).
// Optional build macro YM_PRESC_DYNDIV_EN: reload the half-period from div at every cycle wrap.
module ym_prescaler_prog #(
    parameter int unsigned DIV_W    = 4,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic                 MCLK,
    input  logic                 IC,
    ym_prescaler_prog_if.slave   bus
);
    localparam int unsigned HcW = $clog2(RST_HOLD + 1);
    localparam int unsigned SW  = DIV_W + 1;

    logic             phi_q, phi_d;
    logic [HcW-1:0]   hc_q, hc_d;
    logic [SW-1:0]    s_q, s_d;
    logic [DIV_W-1:0] h_q, h_d;
    logic             c1_q, c1_d;
    logic             c2_q, c2_d;
    logic             cyc_q, cyc_d;

    logic             tick;
    logic             wrap;
    logic             in_hold;
    logic [DIV_W-1:0] div_san;
    logic [SW-1:0]    h_ext;
    logic [SW-1:0]    len;

    // Half-periods below 2 would make the phases overlap, so clamp them to 2.
    assign div_san = (bus.div < DIV_W'(2)) ? DIV_W'(2) : bus.div;

    assign tick    = bus.PHI & ~phi_q;
    assign in_hold = (hc_q != '0);
    assign h_ext   = {1'b0, h_q};
    assign len     = {h_q, 1'b0};
    assign wrap    = (s_q == len - SW'(1));

    always_comb begin
        phi_d = bus.PHI;
        hc_d  = hc_q;
        s_d   = s_q;
        h_d   = h_q;
        c1_d  = c1_q;
        c2_d  = c2_q;
        cyc_d = cyc_q;
        if (tick) begin
            if (in_hold) begin
                hc_d  = hc_q - HcW'(1);
                h_d   = div_san;
                s_d   = '0;
                c1_d  = 1'b0;
                c2_d  = 1'b0;
                cyc_d = 1'b0;
            end else begin
                c1_d  = (s_q == '0) | wrap;
                c2_d  = (s_q == h_ext - SW'(1)) | (s_q == h_ext);
                cyc_d = (s_q == '0);
                s_d   = wrap ? '0 : s_q + SW'(1);
`ifdef YM_PRESC_DYNDIV_EN
                // New ratio only takes effect from the next slot 0.
                if (wrap) begin
                    h_d = div_san;
                end
`endif
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (IC) begin
            phi_q <= 1'b0;
            hc_q  <= HcW'(RST_HOLD);
            s_q   <= '0;
            h_q   <= div_san;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
            cyc_q <= 1'b0;
        end else begin
            phi_q <= phi_d;
            hc_q  <= hc_d;
            s_q   <= s_d;
            h_q   <= h_d;
            c1_q  <= c1_d;
            c2_q  <= c2_d;
            cyc_q <= cyc_d;
        end
    end

    assign bus.c1        = c1_q;
    assign bus.c2        = c2_q;
    assign bus.cyc       = cyc_q;
    assign bus.reset_fsm = in_hold;
endmodule

// File: tb/tb_ym_prescaler_prog.sv
// Bench for ym_prescaler_prog: directed scenarios plus random PHI/div/IC traffic,
// checked every MCLK against a cycle-pattern reference model.
module tb_ym_prescaler_prog;
    localparam int unsigned DIV_W    = 4;
    localparam int unsigned RST_HOLD = 4;

    logic clk;
    logic ic;
    int   checks = 0;
    int   passes = 0;

    ym_prescaler_prog_if #(.DIV_W(DIV_W)) bus ();

    ym_prescaler_prog #(
        .DIV_W   (DIV_W),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .MCLK(clk),
        .IC  (ic),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole cycles are expanded into a queue of {c1,c2,cyc} per tick.
    logic       phi_m;
    int         hold_m;
    int         h_m;
    logic [2:0] out_m;
    logic [2:0] pat_q[$];

    function automatic int san(input logic [DIV_W-1:0] d);
        return (d < 2) ? 2 : int'(d);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic model_update(input logic phi, input logic [DIV_W-1:0] d, input logic ic_v);
        if (ic_v) begin
            phi_m  = 1'b0;
            hold_m = RST_HOLD;
            h_m    = san(d);
            out_m  = 3'b000;
            pat_q.delete();
        end else begin
            if (phi && !phi_m) begin
                if (hold_m > 0) begin
                    hold_m--;
                    h_m   = san(d);
                    out_m = 3'b000;
                end else begin
                    if (pat_q.size() == 0) begin
                        for (int k = 0; k < 2 * h_m; k++) begin
                            pat_q.push_back({(k == 0) || (k == 2 * h_m - 1),
                                             (k == h_m - 1) || (k == h_m),
                                             (k == 0)});
                        end
                    end
                    out_m = pat_q.pop_front();
`ifdef YM_PRESC_DYNDIV_EN
                    if (pat_q.size() == 0) h_m = san(d);
`endif
                end
            end
            phi_m = phi;
        end
    endtask

    task automatic step(input logic phi, input logic [DIV_W-1:0] d, input logic ic_v);
        bus.PHI = phi;
        bus.div = d;
        ic      = ic_v;
        @(posedge clk);
        model_update(phi, d, ic_v);
        @(negedge clk);
        chk("c1", bus.c1, out_m[2]);
        chk("c2", bus.c2, out_m[1]);
        chk("cyc", bus.cyc, out_m[0]);
        chk("reset_fsm", bus.reset_fsm, hold_m != 0);
        chk("no_overlap", bus.c1 & bus.c2, 1'b0);
    endtask

    // PHI toggles every 2 MCLK, giving one tick per 4 MCLK.
    task automatic run_toggle(input int n, input logic [DIV_W-1:0] d);
        for (int i = 0; i < n; i++) step(((i >> 1) & 1) != 0, d, 1'b0);
    endtask

    task automatic pulse_ic(input int n, input logic [DIV_W-1:0] d);
        for (int i = 0; i < n; i++) step(((i >> 1) & 1) != 0, d, 1'b1);
    endtask

    initial begin
        logic [DIV_W-1:0] rd;
        logic             rphi;
        phi_m   = 1'b0;
        hold_m  = RST_HOLD;
        h_m     = 2;
        out_m   = 3'b000;
        bus.PHI = 1'b0;
        bus.div = 4'd3;
        ic      = 1'b1;
        @(negedge clk);

        // Default reset then legacy divide-by-6 pattern.
        pulse_ic(10, 4'd3);
        run_toggle(120, 4'd3);

        // Divider sweep including sanitised values.
        pulse_ic(2, 4'd2);
        run_toggle(80, 4'd2);
        pulse_ic(2, 4'd7);
        run_toggle(160, 4'd7);
        pulse_ic(2, 4'd0);
        run_toggle(80, 4'd0);
        pulse_ic(2, 4'd1);
        run_toggle(80, 4'd1);

        // Mid-run ratio change: 3 -> 2 a few ticks into a cycle.
        pulse_ic(2, 4'd3);
        run_toggle(16 + 24 + 10, 4'd3);
        run_toggle(100, 4'd2);

        // One-MCLK IC pulse mid-operation, then fresh hold.
        run_toggle(13, 4'd3);
        step(1'b1, 4'd3, 1'b1);
        run_toggle(80, 4'd3);

        // PHI stall high, then resume.
        run_toggle(30, 4'd3);
        for (int i = 0; i < 20; i++) step(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd3, 1'b0);
        run_toggle(60, 4'd3);

        // PHI high on the first MCLK after IC release.
        step(1'b0, 4'd4, 1'b1);
        for (int i = 0; i < 60; i++) step((i % 3) != 2, 4'd4, 1'b0);

        // Random traffic.
        rd = 4'd5;
        for (int i = 0; i < 3000; i++) begin
            rphi = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) rd = 4'($urandom_range(0, 15));
            step(rphi, rd, $urandom_range(0, 149) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
